// File: rtl/countdown_timer.sv
// Down-counting HH:MM:SS timer in packed BCD, decremented once per 1 Hz tick.
// Expiry either stops in DONE or reloads the last loaded value (AUTO_RELOAD).
module countdown_timer #(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        tick,
  input  logic        load,
  input  logic [19:0] load_time,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  output logic [19:0] remain_time,
  output logic        running,
  output logic        expired,
  output logic        done_pulse,
  output logic        load_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [19:0] reload;
  logic [19:0] reload_next;
  logic [19:0] remain_next;
  logic [19:0] dec_time;
  logic        done_next;
  logic        err_next;

  function automatic logic time_legal(input logic [19:0] t);
    logic hour_ok;
    hour_ok = (t[19:18] < 2'd2) ? (t[17:14] <= 4'd9)
                                : ((t[19:18] == 2'd2) && (t[17:14] <= 4'd3));
    return hour_ok && (t[13:11] <= 3'd5) && (t[10:7] <= 4'd9) &&
           (t[6:4] <= 3'd5) && (t[3:0] <= 4'd9);
  endfunction

  // Borrow ripples from sec_l upward; a digit only moves when a borrow reaches it.
  function automatic logic [19:0] time_dec(input logic [19:0] t);
    logic [1:0] hh;
    logic [3:0] hl;
    logic [2:0] mh;
    logic [3:0] ml;
    logic [2:0] sh;
    logic [3:0] sl;
    logic       b;
    {hh, hl, mh, ml, sh, sl} = t;
    b = 1'b0;
    if (sl == 4'd0) begin sl = 4'd9; b = 1'b1; end else begin sl = sl - 4'd1; end
    if (b) begin
      if (sh == 3'd0) begin sh = 3'd5; end else begin sh = sh - 3'd1; b = 1'b0; end
    end
    if (b) begin
      if (ml == 4'd0) begin ml = 4'd9; end else begin ml = ml - 4'd1; b = 1'b0; end
    end
    if (b) begin
      if (mh == 3'd0) begin mh = 3'd5; end else begin mh = mh - 3'd1; b = 1'b0; end
    end
    if (b) begin
      if (hl == 4'd0) begin hl = 4'd9; hh = hh - 2'd1; end else begin hl = hl - 4'd1; end
    end
    return {hh, hl, mh, ml, sh, sl};
  endfunction

  // Next-state and next-output logic; controls resolved in clear > load > pause > start > tick order.
  always_comb begin
    state_next  = state;
    remain_next = remain_time;
    reload_next = reload;
    done_next   = 1'b0;
    err_next    = 1'b0;
    dec_time    = time_dec(remain_time);
    if (clear) begin
      state_next  = IDLE;
      remain_next = 20'd0;
    end else if (load) begin
      if (state != RUN) begin
        if (time_legal(load_time)) begin
          remain_next = load_time;
          reload_next = load_time;
          state_next  = IDLE;
        end else begin
          err_next = 1'b1;
        end
      end else begin
        state_next = state;
      end
    end else if (pause) begin
      if (state == RUN) begin
        state_next = PAUSE;
      end else begin
        state_next = state;
      end
    end else if (start) begin
      case (state)
        IDLE, PAUSE: begin
          if (remain_time != 20'd0) begin
            state_next = RUN;
          end else begin
            state_next = state;
          end
        end
        DONE: begin
          if (reload != 20'd0) begin
            remain_next = reload;
            state_next  = RUN;
          end else begin
            state_next = DONE;
          end
        end
        default: state_next = state;
      endcase
    end else if (tick && (state == RUN)) begin
      if (dec_time == 20'd0) begin
        done_next = 1'b1;
        if (AUTO_RELOAD) begin
          remain_next = reload;
        end else begin
          remain_next = 20'd0;
          state_next  = DONE;
        end
      end else begin
        remain_next = dec_time;
      end
    end else begin
      state_next = state;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state       <= IDLE;
      remain_time <= 20'd0;
      reload      <= 20'd0;
      running     <= 1'b0;
      expired     <= 1'b0;
      done_pulse  <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      state       <= state_next;
      remain_time <= remain_next;
      reload      <= reload_next;
      running     <= (state_next == RUN);
      expired     <= (state_next == DONE);
      done_pulse  <= done_next;
      load_err    <= err_next;
    end
  end

endmodule
